// File: rtl/ram8_fifo_pkg.sv
// Shared constants and types for the RAM-backed byte FIFO controller.
package ram8_fifo_pkg;

  localparam int DW     = 8;
  localparam int AW     = 3;
  localparam int DEPTH  = 2 ** AW;
  localparam int CAP    = DEPTH + 1;
  localparam int RD_LAT = 1;

  typedef enum logic [0:0] {
    IDLE,
    RD_WAIT
  } state_t;

  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   cnt_t;

endpackage

// File: rtl/ram8_fifo_ctrl.sv
// Byte FIFO using an external single-port 8x8 RAM plus a first-word-fall-through output register.
// Optional build macro RAM8_FIFO_BYPASS_EN lets a byte skip the RAM when the FIFO is draining empty.
//
// state   | meaning
// IDLE    | RAM port free: issue a read if the output slot can take it, else accept a push
// RD_WAIT | read issued last cycle; capture ram_dout into the output register at this edge
module ram8_fifo_ctrl #(
  parameter int DW = ram8_fifo_pkg::DW,
  parameter int AW = ram8_fifo_pkg::AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena,
  input  logic [DW-1:0] s_data,
  input  logic          s_valid,
  output logic          s_ready,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);
  import ram8_fifo_pkg::*;

  localparam logic [AW:0] DEPTH_C = (AW+1)'(2 ** AW);
  localparam logic [AW:0] CAP_C   = (AW+1)'(2 ** AW + 1);

  state_t        state, state_nxt;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   ram_cnt, ram_cnt_nxt, count_nxt;
  logic          pop, capture, bypass, m_valid_nxt;

  assign pop = ena && m_valid && m_ready;

  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_din   = '0;
    capture   = 1'b0;
    bypass    = 1'b0;
    case (state)
      IDLE: begin
        if (ena) begin
          // Reads win the single RAM port so the output slot refills as fast as possible.
          if (ram_cnt != '0 && (!m_valid || m_ready)) begin
            ram_addr  = rd_ptr;
            state_nxt = RD_WAIT;
          end else begin
            s_ready = (ram_cnt < DEPTH_C);
            if (s_valid && s_ready) begin
`ifdef RAM8_FIFO_BYPASS_EN
              if (ram_cnt == '0 && (!m_valid || m_ready)) begin
                bypass = 1'b1;
              end else begin
                ram_we   = 1'b1;
                ram_addr = wr_ptr;
                ram_din  = s_data;
              end
`else
              ram_we   = 1'b1;
              ram_addr = wr_ptr;
              ram_din  = s_data;
`endif
            end
          end
        end
      end
      RD_WAIT: begin
        // Completes even with ena low so the in-flight byte is not lost.
        capture   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ram_cnt_nxt = ram_cnt + (AW+1)'(ram_we) - (AW+1)'(capture);
    if (capture || bypass) begin
      m_valid_nxt = 1'b1;
    end else if (pop) begin
      m_valid_nxt = 1'b0;
    end else begin
      m_valid_nxt = m_valid;
    end
    count_nxt = ram_cnt_nxt + (AW+1)'(m_valid_nxt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      ram_cnt <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
      count   <= '0;
    end else begin
      state   <= state_nxt;
      ram_cnt <= ram_cnt_nxt;
      m_valid <= m_valid_nxt;
      count   <= count_nxt;
      if (ram_we) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (capture) begin
        rd_ptr <= rd_ptr + AW'(1);
        m_data <= ram_dout;
      end else if (bypass) begin
        m_data <= s_data;
      end
    end
  end

  assign full  = (count == CAP_C);
  assign empty = (count == '0);

endmodule

// File: tb/tb_ram8_fifo_ctrl.sv
// Directed self-checking bench for ram8_fifo_ctrl with a behavioural 8x8 RAM (read latency 1).
module tb_ram8_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, ena;
  logic [7:0] s_data;
  logic       s_valid, s_ready;
  logic [7:0] m_data;
  logic       m_valid, m_ready;
  logic       ram_we;
  logic [2:0] ram_addr;
  logic [7:0] ram_din, ram_dout;
  logic [3:0] count;
  logic       full, empty;

  logic [7:0] mem [8];
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         max_count = 0;
  logic [7:0] obs_q[$];
  int         obs_t[$];

  ram8_fifo_ctrl dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  // RAM macro stand-in: synchronous write, registered read
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (rst_n && ena && m_valid && m_ready) begin
      obs_q.push_back(m_data);
      obs_t.push_back(cyc);
    end
    if (int'(count) > max_count) max_count = int'(count);
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] d);
    int n;
    s_data  = d;
    s_valid = 1'b1;
    #1;
    n = 0;
    while (!s_ready && n < 60) begin
      @(posedge clk);
      #2;
      n++;
    end
    check_val("push_wait", 32'(n < 60), 32'd1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    m_ready = 1'b1;
    n = 0;
    #1;
    while (!empty && n < 200) begin
      tick();
      n++;
    end
    check_val("drain_wait", 32'(n < 200), 32'd1);
    m_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; ena = 1'b1; s_data = '0; s_valid = 1'b0; m_ready = 1'b0;
    #3;
    check_val("rst_m_valid", 32'(m_valid), 32'd0);
    check_val("rst_m_data", 32'(m_data), 32'h0);
    check_val("rst_count", 32'(count), 32'd0);
    check_val("rst_empty", 32'(empty), 32'd1);
    check_val("rst_full", 32'(full), 32'd0);
    check_val("rst_ram_we", 32'(ram_we), 32'd0);
    check_val("rst_ram_addr", 32'(ram_addr), 32'd0);
    check_val("rst_ram_din", 32'(ram_din), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // single byte latency
    s_valid = 1'b1; s_data = 8'hA5;
    #1;
    check_val("lat_s_ready", 32'(s_ready), 32'd1);
`ifdef RAM8_FIFO_BYPASS_EN
    check_val("lat_bypass_we", 32'(ram_we), 32'd0);
    tick();
    s_valid = 1'b0;
    #1;
    check_val("lat_c1_m_valid", 32'(m_valid), 32'd1);
    check_val("lat_c1_m_data", 32'(m_data), 32'hA5);
    check_val("lat_c1_count", 32'(count), 32'd1);
`else
    check_val("lat_c0_we", 32'(ram_we), 32'd1);
    check_val("lat_c0_addr", 32'(ram_addr), 32'd0);
    check_val("lat_c0_din", 32'(ram_din), 32'hA5);
    tick();
    s_valid = 1'b0;
    #1;
    check_val("lat_c1_we", 32'(ram_we), 32'd0);
    check_val("lat_c1_addr", 32'(ram_addr), 32'd0);
    check_val("lat_c1_m_valid", 32'(m_valid), 32'd0);
    tick();
    check_val("lat_c2_m_valid", 32'(m_valid), 32'd0);
    tick();
    check_val("lat_c3_m_valid", 32'(m_valid), 32'd1);
    check_val("lat_c3_m_data", 32'(m_data), 32'hA5);
    check_val("lat_c3_count", 32'(count), 32'd1);
`endif
    drain();
    obs_q.delete(); obs_t.delete();

    // fill to capacity, then drain at full rate
    for (int i = 1; i <= 9; i++) push_byte(8'(i));
    #1;
    check_val("fill_full", 32'(full), 32'd1);
    check_val("fill_count", 32'(count), 32'd9);
    check_val("fill_s_ready", 32'(s_ready), 32'd0);
    drain();
    check_val("fill_nout", 32'(obs_q.size()), 32'd9);
    if (obs_q.size() == 9) begin
      for (int i = 0; i < 9; i++) check_val("fill_order", 32'(obs_q[i]), 32'(i + 1));
      check_val("fill_rate_first", 32'(obs_t[1] - obs_t[0]), 32'd2);
      check_val("fill_rate_span", 32'(obs_t[8] - obs_t[0]), 32'd16);
    end
    check_val("fill_empty", 32'(empty), 32'd1);
    obs_q.delete(); obs_t.delete();

    // interleaved traffic across pointer wrap
    max_count = 0;
    for (int i = 0; i < 6; i++) push_byte(8'(8'h10 + i));
    fork
      begin
        for (int i = 6; i < 20; i++) push_byte(8'(8'h10 + i));
      end
      begin
        for (int i = 0; i < 60; i++) begin
          m_ready = (i % 3 != 2);
          tick();
        end
        m_ready = 1'b0;
      end
    join
    drain();
    check_val("wrap_nout", 32'(obs_q.size()), 32'd20);
    if (obs_q.size() == 20) begin
      for (int i = 0; i < 20; i++) check_val("wrap_order", 32'(obs_q[i]), 32'(8'h10 + i));
    end
    check_val("wrap_max_count", 32'(max_count <= 9), 32'd1);
    obs_q.delete(); obs_t.delete();

    // reset while a read is in flight
    push_byte(8'h71); push_byte(8'h72); push_byte(8'h73);
    tick(); tick(); tick();
    check_val("rrst_pre_count", 32'(count), 32'd3);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check_val("rrst_m_valid", 32'(m_valid), 32'd0);
    check_val("rrst_count", 32'(count), 32'd0);
    check_val("rrst_empty", 32'(empty), 32'd1);
    tick();
    rst_n = 1'b1;
    tick();
    obs_q.delete(); obs_t.delete();
    push_byte(8'h5A);
    begin
      int n = 0;
      while (!m_valid && n < 20) begin tick(); n++; end
    end
    check_val("rrst_m_data", 32'(m_data), 32'h5A);
    check_val("rrst_count1", 32'(count), 32'd1);
    drain();
    check_val("rrst_nout", 32'(obs_q.size()), 32'd1);
    obs_q.delete(); obs_t.delete();

    // ena low with a read in flight and a push pending
    push_byte(8'h61); push_byte(8'h62);
    tick(); tick(); tick();
    check_val("ena_pre_count", 32'(count), 32'd2);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0; ena = 1'b0; s_valid = 1'b1; s_data = 8'h63;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_val("ena_ram_we", 32'(ram_we), 32'd0);
      check_val("ena_s_ready", 32'(s_ready), 32'd0);
      tick();
    end
    check_val("ena_cap_valid", 32'(m_valid), 32'd1);
    check_val("ena_cap_data", 32'(m_data), 32'h62);
    check_val("ena_count", 32'(count), 32'd1);
    ena = 1'b1; s_valid = 1'b0;
    push_byte(8'h63);
    drain();
    check_val("ena_nout", 32'(obs_q.size()), 32'd3);
    if (obs_q.size() == 3) begin
      check_val("ena_out0", 32'(obs_q[0]), 32'h61);
      check_val("ena_out1", 32'(obs_q[1]), 32'h62);
      check_val("ena_out2", 32'(obs_q[2]), 32'h63);
    end
    obs_q.delete(); obs_t.delete();

`ifdef RAM8_FIFO_BYPASS_EN
    s_valid = 1'b1; s_data = 8'h3C;
    #1;
    check_val("byp_s_ready", 32'(s_ready), 32'd1);
    check_val("byp_ram_we", 32'(ram_we), 32'd0);
    tick();
    s_valid = 1'b0;
    #1;
    check_val("byp_m_valid", 32'(m_valid), 32'd1);
    check_val("byp_m_data", 32'(m_data), 32'h3C);
    check_val("byp_ram_we1", 32'(ram_we), 32'd0);
    drain();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
